fetch_unit: RTL and testbench

Instruction fetch and issue stage that generates the opcode stream consumed by the control unit. Maintains the PC, runs a request/acknowledge handshake with instruction memory, assembles two-word instructions (opcode word plus immediate word) into a single issue, and squashes in-flight fetches on a taken jump. It sits between instruction memory and the decode/control stage and presents at most one issued instruction per cycle.

---
 rtl/isa_pkg.sv | 29 ++
 rtl/pc_reg.sv | 42 ++++
 rtl/fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_fetch_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : isa_pkg
// Brief    : Opcode constants, two-word opcode decode and fetch FSM states.
// Revision : 1.0
// ============================================================================
package isa_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_NOP = 5'd0;
    localparam logic [OPC_W-1:0] OP_LDM = 5'd14;
    localparam logic [OPC_W-1:0] OP_JMP = 5'd19;
    localparam logic [OPC_W-1:0] OP_SHL = 5'd30;
    localparam logic [OPC_W-1:0] OP_SHR = 5'd31;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_IMM   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // Opcodes whose immediate lives in the following memory word.
    function automatic logic is_two_word(input logic [OPC_W-1:0] op);
        return (op == OP_LDM) || (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module   : pc_reg
// Brief    : Program counter with load (priority) and modulo-2^PC_W increment.
// Revision : 1.0
// ============================================================================
module pc_reg #(
    parameter int              PC_W     = 20,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [PC_W-1:0] load_pc_i,
    input  logic            inc_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (inc_i) begin
            pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch/issue stage with two-word assembly and redirect.
// Revision : 1.0
// ============================================================================
module fetch_unit
    import isa_pkg::*;
#(
    parameter int              PC_W     = 20,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               instr_valid,
    output logic [OPC_W-1:0]   opcode,
    output logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] imm,
    output logic [PC_W-1:0]    issue_pc
);

    fetch_state_e        state_q, state_d;
    logic                run_q;
    logic [PC_W-1:0]     pc;
    logic                pc_load, pc_inc;
    logic [INSTR_W-1:0]  first_q, first_d;
    logic [PC_W-1:0]     first_pc_q, first_pc_d;
    logic [PC_W-1:0]     drain_addr_q, drain_addr_d;

    logic                iv_q, iv_d;
    logic [INSTR_W-1:0]  iinstr_q, iinstr_d;
    logic [INSTR_W-1:0]  iimm_q, iimm_d;
    logic [PC_W-1:0]     ipc_q, ipc_d;

    logic                new_valid;
    logic [INSTR_W-1:0]  new_instr, new_imm;
    logic [PC_W-1:0]     new_pc;

    logic                w_slot_free;
    logic                w_ack;
    logic [OPC_W-1:0]    w_op;

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (pc_load),
        .load_pc_i (redirect_pc),
        .inc_i     (pc_inc),
        .pc_o      (pc)
    );

    // Any completing fetch may produce an issue, so only request while the slot can take it.
    assign w_slot_free = !iv_q || !stall;
    assign imem_req    = (state_q == ST_DRAIN) ? 1'b1 : (run_q && w_slot_free);
    assign imem_addr   = (state_q == ST_DRAIN) ? drain_addr_q : pc;
    assign w_ack       = imem_req && imem_ack;
    assign w_op        = imem_rdata[INSTR_W-1 -: OPC_W];

    always_comb begin
        state_d      = state_q;
        first_d      = first_q;
        first_pc_d   = first_pc_q;
        drain_addr_d = drain_addr_q;
        pc_load      = 1'b0;
        pc_inc       = 1'b0;
        new_valid    = 1'b0;
        new_instr    = '0;
        new_imm      = '0;
        new_pc       = '0;
        if (redirect) begin
            pc_load = 1'b1;
            if (imem_req && !imem_ack) begin
                state_d = ST_DRAIN;
                if (state_q != ST_DRAIN) begin
                    drain_addr_d = pc;
                end
            end else begin
                state_d = ST_FETCH;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (w_ack) begin
                        pc_inc = 1'b1;
                        if (is_two_word(w_op)) begin
                            first_d    = imem_rdata;
                            first_pc_d = pc;
                            state_d    = ST_IMM;
                        end else begin
                            new_valid = 1'b1;
                            new_instr = imem_rdata;
                            new_pc    = pc;
                        end
                    end
                end
                ST_IMM: begin
                    if (w_ack) begin
                        pc_inc    = 1'b1;
                        new_valid = 1'b1;
                        new_instr = first_q;
                        new_imm   = imem_rdata;
                        new_pc    = first_pc_q;
                        state_d   = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack) begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_comb begin
        iv_d     = iv_q;
        iinstr_d = iinstr_q;
        iimm_d   = iimm_q;
        ipc_d    = ipc_q;
        if (redirect) begin
            iv_d     = 1'b0;
            iinstr_d = '0;
            iimm_d   = '0;
            ipc_d    = '0;
        end else if (w_slot_free) begin
            iv_d     = new_valid;
            iinstr_d = new_instr;
            iimm_d   = new_imm;
            ipc_d    = new_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            run_q        <= 1'b0;
            first_q      <= '0;
            first_pc_q   <= '0;
            drain_addr_q <= '0;
            iv_q         <= 1'b0;
            iinstr_q     <= '0;
            iimm_q       <= '0;
            ipc_q        <= '0;
        end else begin
            state_q      <= state_d;
            run_q        <= 1'b1;
            first_q      <= first_d;
            first_pc_q   <= first_pc_d;
            drain_addr_q <= drain_addr_d;
            iv_q         <= iv_d;
            iinstr_q     <= iinstr_d;
            iimm_q       <= iimm_d;
            ipc_q        <= ipc_d;
        end
    end

    assign instr_valid = iv_q;
    assign opcode      = iinstr_q[INSTR_W-1 -: OPC_W];
    assign instr       = iinstr_q;
    assign imm         = iimm_q;
    assign issue_pc    = ipc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed and randomized checks of fetch_unit against a stream model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    localparam int              PC_W     = 20;
    localparam int              INSTR_W  = 16;
    localparam logic [PC_W-1:0] RESET_PC = '0;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack = 1'b0;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               stall = 1'b0;
    logic               redirect = 1'b0;
    logic [PC_W-1:0]    redirect_pc = '0;
    logic               instr_valid;
    logic [4:0]         opcode;
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] imm;
    logic [PC_W-1:0]    issue_pc;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .opcode(opcode), .instr(instr), .imm(imm), .issue_pc(issue_pc)
    );

    always #5 clk = ~clk;

    // Memory model: 256-word image aliased over the address space, ack after `lat` waiting cycles.
    logic [INSTR_W-1:0] mem [256];
    int   lat       = 0;
    int   wait_cnt  = 0;
    bit   rand_lat  = 1'b0;
    bit   force_ack = 1'b0;

    always @(negedge clk) begin
        imem_ack   = force_ack || (imem_req && (wait_cnt >= lat));
        imem_rdata = mem[imem_addr[7:0]];
        if (imem_req && !imem_ack) wait_cnt = wait_cnt + 1;
        else                       wait_cnt = 0;
        if (imem_req && imem_ack && rand_lat) lat = $urandom_range(0, 2);
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_mem();
        for (int i = 0; i < 256; i++) mem[i] = {5'(i % 13 + 1), 11'(i * 7)};
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    function automatic bit two_word(input logic [INSTR_W-1:0] w);
        return (w[15:11] == 5'd14) || (w[15:11] == 5'd30) || (w[15:11] == 5'd31);
    endfunction

    task automatic test_reset();
        init_mem(); lat = 0; rand_lat = 1'b0;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0;
        tick();
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", imem_req); end
        n_tests++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
        n_tests++; if (opcode !== 5'd0) begin n_fail++; $display("FAIL reset_opcode: got %0d want 0", opcode); end
        n_tests++; if (instr !== '0 || imm !== '0) begin n_fail++; $display("FAIL reset_instr_imm: got %h/%h want 0/0", instr, imm); end
        n_tests++; if (issue_pc !== '0) begin n_fail++; $display("FAIL reset_issue_pc: got %h want 0", issue_pc); end
        rst_n = 1'b1;
        tick();
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_req_rise: got %0b want 1", imem_req); end
    endtask

    task automatic test_sequential();
        logic [4:0] ops [4];
        ops[0] = 5'd25; ops[1] = 5'd26; ops[2] = 5'd1; ops[3] = 5'd24;
        init_mem(); lat = 0;
        for (int i = 0; i < 4; i++) mem[i] = {ops[i], 11'(i + 3)};
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (instr_valid !== 1'b1 || opcode !== ops[i] || issue_pc !== PC_W'(i))
                begin n_fail++; $display("FAIL seq_issue%0d: got v=%0b op=%0d pc=%h want v=1 op=%0d pc=%h", i, instr_valid, opcode, issue_pc, ops[i], i); end
        end
    endtask

    task automatic test_two_word();
        init_mem(); lat = 0;
        mem[4] = {5'd14, 11'h055};
        mem[5] = 16'h1234;
        mem[6] = {5'd2, 11'h011};
        do_reset();
        tick();
        repeat (4) tick();
        tick();
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ldm_first_alone: got v=%0b pc=%h want v=0", instr_valid, issue_pc); end
        tick();
        n_tests++;
        if (instr_valid !== 1'b1 || opcode !== 5'd14 || imm !== 16'h1234 || issue_pc !== 20'h4 || instr !== mem[4])
            begin n_fail++; $display("FAIL ldm_issue: got v=%0b op=%0d imm=%h pc=%h want v=1 op=14 imm=1234 pc=4", instr_valid, opcode, imm, issue_pc); end
        tick();
        n_tests++;
        if (instr_valid !== 1'b1 || issue_pc !== 20'h6 || imm !== '0 || opcode !== 5'd2)
            begin n_fail++; $display("FAIL after_ldm: got v=%0b pc=%h imm=%h op=%0d want v=1 pc=6 imm=0 op=2", instr_valid, issue_pc, imm, opcode); end
    endtask

    task automatic test_stall();
        init_mem(); lat = 0;
        do_reset();
        tick(); tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (instr_valid !== 1'b1 || issue_pc !== 20'h0 || instr !== mem[0] || imem_req !== 1'b0 || imem_addr !== 20'h1)
                begin n_fail++; $display("FAIL stall_hold%0d: got v=%0b pc=%h instr=%h req=%0b addr=%h want v=1 pc=0 instr=%h req=0 addr=1", i, instr_valid, issue_pc, instr, imem_req, imem_addr, mem[0]); end
        end
        stall = 1'b0;
        tick();
        n_tests++;
        if (instr_valid !== 1'b1 || issue_pc !== 20'h1 || opcode !== mem[1][15:11])
            begin n_fail++; $display("FAIL stall_resume: got v=%0b pc=%h op=%0d want v=1 pc=1 op=%0d", instr_valid, issue_pc, opcode, mem[1][15:11]); end
    endtask

    task automatic test_redirect_stall();
        init_mem(); lat = 0;
        do_reset();
        tick(); tick();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 20'h20;
        tick();
        redirect = 1'b0;
        n_tests++;
        if (instr_valid !== 1'b0 || opcode !== 5'd0 || imm !== '0 || imem_addr !== 20'h20)
            begin n_fail++; $display("FAIL redir_stall_nop: got v=%0b op=%0d imm=%h addr=%h want v=0 op=0 imm=0 addr=20", instr_valid, opcode, imm, imem_addr); end
        tick();
        n_tests++;
        if (instr_valid !== 1'b1 || issue_pc !== 20'h20 || instr !== mem[8'h20])
            begin n_fail++; $display("FAIL redir_stall_target: got v=%0b pc=%h want v=1 pc=20", instr_valid, issue_pc); end
        stall = 1'b0;
    endtask

    task automatic test_redirect_drain();
        bit seen;
        init_mem(); lat = 2;
        do_reset();
        tick(); tick();
        redirect = 1'b1; redirect_pc = 20'h40;
        tick();
        redirect = 1'b0;
        n_tests++;
        if (instr_valid !== 1'b0 || opcode !== 5'd0 || imem_req !== 1'b1 || imem_addr !== 20'h0)
            begin n_fail++; $display("FAIL drain_hold: got v=%0b op=%0d req=%0b addr=%h want v=0 op=0 req=1 addr=0", instr_valid, opcode, imem_req, imem_addr); end
        tick();
        n_tests++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 20'h40)
            begin n_fail++; $display("FAIL drain_refetch: got v=%0b req=%0b addr=%h want v=0 req=1 addr=40", instr_valid, imem_req, imem_addr); end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (instr_valid === 1'b1) begin
                seen = 1'b1;
                n_tests++;
                if (issue_pc !== 20'h40 || opcode !== mem[8'h40][15:11])
                    begin n_fail++; $display("FAIL drain_target: got pc=%h op=%0d want pc=40 op=%0d", issue_pc, opcode, mem[8'h40][15:11]); end
            end
        end
        if (!seen) begin n_tests++; n_fail++; $display("FAIL drain_timeout: got no issue want issue at 40"); end
        lat = 0;
    endtask

    task automatic test_wrap();
        init_mem(); lat = 0;
        do_reset();
        tick();
        redirect = 1'b1; redirect_pc = 20'hFFFFF;
        tick();
        redirect = 1'b0;
        n_tests++;
        if (instr_valid !== 1'b0 || imem_addr !== 20'hFFFFF)
            begin n_fail++; $display("FAIL wrap_redir: got v=%0b addr=%h want v=0 addr=fffff", instr_valid, imem_addr); end
        tick();
        n_tests++;
        if (instr_valid !== 1'b1 || issue_pc !== 20'hFFFFF || imem_addr !== 20'h0)
            begin n_fail++; $display("FAIL wrap_addr: got v=%0b pc=%h addr=%h want v=1 pc=fffff addr=0", instr_valid, issue_pc, imem_addr); end
        tick();
        n_tests++;
        if (instr_valid !== 1'b1 || issue_pc !== 20'h0 || instr !== mem[0])
            begin n_fail++; $display("FAIL wrap_next: got v=%0b pc=%h want v=1 pc=0", instr_valid, issue_pc); end
    endtask

    task automatic test_reset_mid_imm();
        init_mem(); lat = 0;
        mem[0] = {5'd14, 11'h0AA};
        mem[1] = 16'hBEEF;
        do_reset();
        tick(); tick();
        n_tests++;
        if (instr_valid !== 1'b0 || imem_addr !== 20'h1)
            begin n_fail++; $display("FAIL imm_state: got v=%0b addr=%h want v=0 addr=1", instr_valid, imem_addr); end
        rst_n = 1'b0; force_ack = 1'b1;
        #1;
        n_tests++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || instr_valid !== 1'b0 || opcode !== 5'd0 || imm !== '0 || instr !== '0)
            begin n_fail++; $display("FAIL mid_reset: got req=%0b addr=%h v=%0b op=%0d imm=%h instr=%h want all 0", imem_req, imem_addr, instr_valid, opcode, imm, instr); end
        tick(); tick();
        force_ack = 1'b0; rst_n = 1'b1;
        tick(); tick();
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_gap: got v=%0b want 0", instr_valid); end
        tick();
        n_tests++;
        if (instr_valid !== 1'b1 || opcode !== 5'd14 || imm !== 16'hBEEF || issue_pc !== 20'h0)
            begin n_fail++; $display("FAIL post_reset_ldm: got v=%0b op=%0d imm=%h pc=%h want v=1 op=14 imm=beef pc=0", instr_valid, opcode, imm, issue_pc); end
    endtask

    // Stream model: each fresh issue must be the next program-order instruction from the last
    // redirect target; a stalled valid issue must hold; a redirect leaves a NOP behind it.
    logic [PC_W-1:0]    exp_pc;
    logic               p_valid, p_stall, p_redir;
    logic [INSTR_W-1:0] p_instr, p_imm;
    logic [PC_W-1:0]    p_pc;
    int                 n_issued;

    task automatic test_random();
        logic [INSTR_W-1:0] w0, exp_imm;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            if ($urandom_range(0, 3) == 0) mem[i][15:11] = ($urandom_range(0, 1) == 0) ? 5'd14 : 5'd30 + 5'($urandom_range(0, 1));
        end
        rand_lat = 1'b1; lat = $urandom_range(0, 2);
        do_reset();
        exp_pc = RESET_PC; n_issued = 0;
        p_valid = 1'b0; p_stall = 1'b0; p_redir = 1'b0; p_instr = '0; p_imm = '0; p_pc = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick();
            if (!instr_valid) begin
                n_tests++;
                if (opcode !== 5'd0) begin n_fail++; $display("FAIL rnd_nop_opcode: cyc %0d got %0d want 0", cyc, opcode); end
            end
            if (p_redir) begin
                n_tests++;
                if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_redir_nop: cyc %0d got v=%0b want 0", cyc, instr_valid); end
            end else if (p_valid && p_stall) begin
                n_tests++;
                if (instr_valid !== 1'b1 || instr !== p_instr || imm !== p_imm || issue_pc !== p_pc)
                    begin n_fail++; $display("FAIL rnd_stall_hold: cyc %0d got v=%0b instr=%h imm=%h pc=%h want v=1 instr=%h imm=%h pc=%h", cyc, instr_valid, instr, imm, issue_pc, p_instr, p_imm, p_pc); end
            end else if (instr_valid) begin
                w0 = mem[exp_pc[7:0]];
                exp_imm = two_word(w0) ? mem[8'(exp_pc[7:0] + 8'd1)] : '0;
                n_tests++;
                if (issue_pc !== exp_pc || instr !== w0 || imm !== exp_imm || opcode !== w0[15:11])
                    begin n_fail++; $display("FAIL rnd_issue: cyc %0d got pc=%h instr=%h imm=%h want pc=%h instr=%h imm=%h", cyc, issue_pc, instr, imm, exp_pc, w0, exp_imm); end
                exp_pc = exp_pc + (two_word(w0) ? 20'd2 : 20'd1);
                n_issued++;
            end
            p_valid = instr_valid; p_instr = instr; p_imm = imm; p_pc = issue_pc;
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 29) == 0);
            if (redirect) begin
                redirect_pc = ($urandom_range(0, 3) == 0) ? PC_W'($urandom) : PC_W'($urandom_range(0, 255));
                exp_pc = redirect_pc;
            end
            p_stall = stall; p_redir = redirect;
        end
        stall = 1'b0; redirect = 1'b0; rand_lat = 1'b0; lat = 0;
        n_tests++;
        if (n_issued < 100) begin n_fail++; $display("FAIL rnd_progress: got %0d issues want >= 100", n_issued); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_two_word();
        test_stall();
        test_redirect_stall();
        test_redirect_drain();
        test_wrap();
        test_reset_mid_imm();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
